// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation codes used by the decoder/control unit
// and by the EX-stage multiply/divide unit, plus the unit's FSM state type.
package mdu_pkg;

    localparam int MDU_OP_W = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for the multi-cycle operations that occupy the unit.
    function automatic logic is_long_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for the operations whose result commits after the multiply latency.
    function automatic logic is_mult_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit. Owns HI/LO, computes the product/quotient at
// issue into shadow registers, then holds Busy for the modelled latency before
// committing the shadow values to HI/LO.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                Start,
    input  logic [MDU_OP_W-1:0] MDUOp,
    input  logic [31:0]         S1,
    input  logic [31:0]         S2,
    output logic                Busy,
    output logic [31:0]         HI,
    output logic [31:0]         LO,
    output logic [31:0]         MDUResult
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_e        state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [31:0]       shadow_hi_reg;
    logic [31:0]       shadow_lo_reg;
    logic [31:0]       hi_reg;
    logic [31:0]       lo_reg;
    logic              busy_reg;
    logic [1:0]        rst_sync_reg;
    logic              rst_n;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] sdiv_q;
    logic signed [31:0] sdiv_r;
    logic [31:0]        udiv_q;
    logic [31:0]        udiv_r;
    logic [31:0]        issue_hi;
    logic [31:0]        issue_lo;
    logic [CNT_W-1:0]   issue_lat;

    // Reset asserts immediately, releases two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    // Issue-time arithmetic; a zero divisor keeps HI/LO by reloading them.
    always_comb begin
        prod_s  = $signed({{32{S1[31]}}, S1}) * $signed({{32{S2[31]}}, S2});
        prod_u  = {32'd0, S1} * {32'd0, S2};
        divisor = (S2 == 32'd0) ? 32'd1 : S2;
        if ((S1 == 32'h8000_0000) && (S2 == 32'hFFFF_FFFF)) begin
            // Most-negative / -1 overflows; wrap the quotient, no trap.
            sdiv_q = 32'sh8000_0000;
            sdiv_r = 32'sd0;
        end else begin
            sdiv_q = $signed(S1) / $signed(divisor);
            sdiv_r = $signed(S1) % $signed(divisor);
        end
        udiv_q = S1 / divisor;
        udiv_r = S1 % divisor;

        issue_hi  = hi_reg;
        issue_lo  = lo_reg;
        issue_lat = is_mult_op(MDUOp) ? MULT_LOAD : DIV_LOAD;
        case (MDUOp)
            MDU_MULT:  {issue_hi, issue_lo} = prod_s;
            MDU_MULTU: {issue_hi, issue_lo} = prod_u;
            MDU_DIV: begin
                if (S2 != 32'd0) begin
                    issue_hi = sdiv_r;
                    issue_lo = sdiv_q;
                end
            end
            MDU_DIVU: begin
                if (S2 != 32'd0) begin
                    issue_hi = udiv_r;
                    issue_lo = udiv_q;
                end
            end
            default: ;
        endcase
    end

    // Control FSM, latency counter, shadow results and architectural HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            shadow_hi_reg <= 32'd0;
            shadow_lo_reg <= 32'd0;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        if (is_long_op(MDUOp)) begin
                            shadow_hi_reg <= issue_hi;
                            shadow_lo_reg <= issue_lo;
                            count_reg     <= issue_lat;
                            busy_reg      <= 1'b1;
                            state_reg     <= ST_RUN;
                        end else if (MDUOp == MDU_MTHI) begin
                            hi_reg <= S1;
                        end else if (MDUOp == MDU_MTLO) begin
                            lo_reg <= S1;
                        end
                    end
                end
                ST_RUN: begin
                    if (count_reg == CNT_ONE) begin
                        hi_reg    <= shadow_hi_reg;
                        lo_reg    <= shadow_lo_reg;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        count_reg <= count_reg - CNT_ONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // mfhi/mflo read path into the EX result mux.
    always_comb begin
        MDUResult = 32'd0;
        if (MDUOp == MDU_MFHI) begin
            MDUResult = hi_reg;
        end else if (MDUOp == MDU_MFLO) begin
            MDUResult = lo_reg;
        end
    end

    assign Busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed corner cases followed by random
// operations, checked against a 64-bit arithmetic reference model of HI/LO.
module tb_ex_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic [31:0] S1 = 32'd0;
    logic [31:0] S2 = 32'd0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUResult;

    int          total = 0;
    int          passed = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .MDUOp(MDUOp),
        .S1(S1), .S2(S2), .Busy(Busy), .HI(HI), .LO(LO), .MDUResult(MDUResult)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: architectural effect of one accepted operation on HI/LO.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p, x, y, q, r;
        case (op)
            4'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            4'd2: begin
                p = longint'({32'd0, a}) * longint'({32'd0, b});
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            4'd3: if (b != 0) begin
                x = longint'($signed(a)); y = longint'($signed(b));
                q = x / y; r = x % y;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            4'd4: if (b != 0) begin
                x = longint'({32'd0, a}); y = longint'({32'd0, b});
                q = x / y; r = x % y;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit intrude, input logic [3:0] iop);
        int lat;
        logic [31:0] pre_hi, pre_lo;
        lat = (op == 4'd1 || op == 4'd2) ? MC : DC;
        pre_hi = m_hi;
        pre_lo = m_lo;
        @(negedge clk);
        Start = 1'b1; MDUOp = op; S1 = a; S2 = b;
        model(op, a, b);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check({tag, " busy"}, 32'(Busy), 32'd1);
            if (k == lat) begin
                check({tag, " hi held"}, HI, pre_hi);
                check({tag, " lo held"}, LO, pre_lo);
            end
            if (intrude && k == 2) begin
                Start = 1'b1; MDUOp = iop; S1 = 32'd1234; S2 = 32'd3;
            end else begin
                Start = 1'b0; MDUOp = 4'd0; S1 = $urandom; S2 = $urandom;
            end
        end
        @(negedge clk);
        check({tag, " done"}, 32'(Busy), 32'd0);
        check({tag, " hi"}, HI, m_hi);
        check({tag, " lo"}, LO, m_lo);
        $display("op %s a=%h b=%h -> HI=%h LO=%h", tag, a, b, HI, LO);
    endtask

    task automatic mt_op(input string tag, input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        Start = 1'b1; MDUOp = op; S1 = a;
        model(op, a, 32'd0);
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        check({tag, " busy"}, 32'(Busy), 32'd0);
        check({tag, " hi"}, HI, m_hi);
        check({tag, " lo"}, LO, m_lo);
        $display("op %s a=%h -> HI=%h LO=%h", tag, a, HI, LO);
    endtask

    task automatic mf_check(input string tag);
        @(negedge clk);
        Start = 1'b1; MDUOp = 4'd7;
        #1 check({tag, " mfhi"}, MDUResult, m_hi);
        MDUOp = 4'd8;
        #1 check({tag, " mflo"}, MDUResult, m_lo);
        MDUOp = 4'd0;
        #1 check({tag, " none"}, MDUResult, 32'd0);
        Start = 1'b0;
        $display("op %s -> HI=%h LO=%h", tag, m_hi, m_lo);
    endtask

    task automatic null_op(input string tag, input logic [3:0] op);
        @(negedge clk);
        Start = 1'b1; MDUOp = op; S1 = $urandom; S2 = $urandom;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        check({tag, " busy"}, 32'(Busy), 32'd0);
        check({tag, " hi"}, HI, m_hi);
        check({tag, " lo"}, LO, m_lo);
        $display("op %s code=%0d -> HI=%h LO=%h", tag, op, HI, LO);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        // Reset state
        #12;
        check("reset busy", 32'(Busy), 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed cases
        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 4'd0);
        check("mult hi const", HI, 32'hFFFF_FFFF);
        check("mult lo const", LO, 32'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 4'd0);
        check("multu hi const", HI, 32'h0000_0001);
        check("multu lo const", LO, 32'hFFFF_FFFE);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 4'd0);
        check("div lo const", LO, 32'hFFFF_FFFD);
        check("div hi const", HI, 32'hFFFF_FFFF);
        run_op("divu", 4'd4, 32'd7, 32'd2, 1'b0, 4'd0);
        check("divu lo const", LO, 32'd3);
        check("divu hi const", HI, 32'd1);
        mt_op("mthi", 4'd5, 32'd5);
        mt_op("mtlo", 4'd6, 32'd6);
        run_op("div0", 4'd3, 32'h1234_5678, 32'd0, 1'b0, 4'd0);
        check("div0 hi const", HI, 32'd5);
        check("div0 lo const", LO, 32'd6);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd0);
        check("divovf lo const", LO, 32'h8000_0000);
        check("divovf hi const", HI, 32'd0);
        run_op("mult+mthi", 4'd1, 32'd3, 32'd4, 1'b1, 4'd5);
        check("mthi ignored", HI, 32'd0);
        run_op("divu+div", 4'd4, 32'd100, 32'd7, 1'b1, 4'd3);
        mt_op("mtlo55", 4'd6, 32'd55);
        mf_check("mf55");
        check("mflo const", m_lo, 32'd55);
        null_op("op0", 4'd0);
        null_op("op9", 4'd9);
        null_op("op15", 4'd15);

        // Reset in the middle of a divide
        @(negedge clk);
        Start = 1'b1; MDUOp = 4'd3; S1 = 32'd77; S2 = 32'd5;
        @(negedge clk); Start = 1'b0; MDUOp = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort busy", 32'(Busy), 32'd0);
        check("abort hi", HI, 32'd0);
        check("abort lo", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk); reset_n = 1'b1;
        repeat (DC + 3) @(negedge clk);
        check("post abort busy", 32'(Busy), 32'd0);
        check("post abort hi", HI, 32'd0);
        check("post abort lo", LO, 32'd0);
        $display("op abort-div -> HI=%h LO=%h", HI, LO);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 3) == 0) b = 32'd0;
            if (op == 4'd3 && $urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end
            if (op >= 4'd1 && op <= 4'd4) run_op("rnd", op, a, b, ($urandom_range(0, 1) == 1), 4'($urandom_range(1, 6)));
            else if (op == 4'd5 || op == 4'd6) mt_op("rnd-mt", op, a);
            else if (op == 4'd7 || op == 4'd8) mf_check("rnd-mf");
            else null_op("rnd-null", op);
        end
        mf_check("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
